sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider_if.sv | 23 ++
 rtl/sequential_divider.sv | 144 ++++++++++++++
 tb/tb_sequential_divider.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// rtl/sequential_divider_if.sv - request/result bundle for the sequential divider
interface sequential_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             divByZero;
    logic             busy;
    logic             quotientDone;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, divByZero, busy, quotientDone
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, divByZero, busy, quotientDone
    );
endinterface

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - fixed-latency restoring divider, one quotient bit per cycle
// Optional DIVIDER_EARLY_EXIT_EN: short-circuits divisor==0 / dividend<divisor (data-dependent latency).
module sequential_divider #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sequential_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           nextState;
    logic             accept;
    logic             busyC;
    logic             lastStep;

    // quoReg starts as the dividend and shifts quotient bits in from the LSB
    logic [WIDTH:0]   remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic [CW-1:0]    iterCnt;

    logic [WIDTH-1:0] quotientReg;
    logic [WIDTH-1:0] remainderReg;
    logic             divByZeroReg;
    logic             quotientDoneReg;

    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remSub;
    logic             stepGe;
    logic [WIDTH-1:0] quoNext;

`ifdef DIVIDER_EARLY_EXIT_EN
    logic             earlyReg;
`endif

    always_comb begin
        remShift = (remReg << 1) | {{WIDTH{1'b0}}, quoReg[WIDTH-1]};
        stepGe   = (remShift >= {1'b0, divisorReg});
        remSub   = remShift - {1'b0, divisorReg};
        quoNext  = quoReg << 1;
        quoNext[0] = stepGe;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        busyC     = 1'b0;
        // the done cycle is already IDLE, but a new request waits one more edge
        accept    = (state == IDLE) && bus.start && !quotientDoneReg;
`ifdef DIVIDER_EARLY_EXIT_EN
        lastStep  = (iterCnt == LAST_ITER) || earlyReg;
`else
        lastStep  = (iterCnt == LAST_ITER);
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = CALC;
                end
            end
            CALC: begin
                busyC = 1'b1;
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busyC     = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remReg          <= '0;
            quoReg          <= '0;
            divisorReg      <= '0;
            iterCnt         <= '0;
            quotientReg     <= '0;
            remainderReg    <= '0;
            divByZeroReg    <= 1'b0;
            quotientDoneReg <= 1'b0;
`ifdef DIVIDER_EARLY_EXIT_EN
            earlyReg        <= 1'b0;
`endif
        end else begin
            quotientDoneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        quoReg     <= bus.dividend;
                        divisorReg <= bus.divisor;
                        remReg     <= '0;
                        iterCnt    <= '0;
`ifdef DIVIDER_EARLY_EXIT_EN
                        earlyReg   <= (bus.divisor == '0) || (bus.dividend < bus.divisor);
`endif
                    end
                end
                CALC: begin
                    iterCnt <= iterCnt + CW'(1);
`ifdef DIVIDER_EARLY_EXIT_EN
                    if (earlyReg) begin
                        remReg <= {1'b0, quoReg};
                        quoReg <= (divisorReg == '0) ? '1 : '0;
                    end else
`endif
                    begin
                        // divisor 0 naturally yields all-ones quotient and remainder = dividend
                        remReg <= stepGe ? remSub : remShift;
                        quoReg <= quoNext;
                    end
                end
                DONE: begin
                    quotientReg     <= quoReg;
                    remainderReg    <= remReg[WIDTH-1:0];
                    divByZeroReg    <= (divisorReg == '0);
                    quotientDoneReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient     = quotientReg;
    assign bus.remainder    = remainderReg;
    assign bus.divByZero    = divByZeroReg;
    assign bus.quotientDone = quotientDoneReg;
    assign bus.busy         = busyC;
endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - scoreboard bench for sequential_divider (two instances)
module tb_sequential_divider;
    localparam int W = 4;

    typedef struct {
        int q;
        int r;
        int dz;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t e1;
    exp_t e2;

    sequential_divider_if #(.WIDTH(W)) bus ();
    sequential_divider_if #(.WIDTH(W)) bus2 ();

    sequential_divider #(.WIDTH(W)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    sequential_divider #(.WIDTH(W)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int lat(input int a, input int b);
`ifdef DIVIDER_EARLY_EXIT_EN
        if (b == 0 || a < b) return 2;
`endif
        return W + 1;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.quotientDone) begin
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_spurious_done at cycle %0d: got quotient=%0d remainder=%0d, expected no result",
                         cyc, bus.quotient, bus.remainder);
            end else begin
                e1 = sb1.pop_front();
                chk("dut1_quotient", int'(bus.quotient), e1.q);
                chk("dut1_remainder", int'(bus.remainder), e1.r);
                chk("dut1_divByZero", int'(bus.divByZero), e1.dz);
                chk("dut1_done_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus2.quotientDone) begin
            if (sb2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_spurious_done at cycle %0d: got quotient=%0d, expected no result",
                         cyc, bus2.quotient);
            end else begin
                e2 = sb2.pop_front();
                chk("dut2_quotient", int'(bus2.quotient), e2.q);
                chk("dut2_remainder", int'(bus2.remainder), e2.r);
                chk("dut2_divByZero", int'(bus2.divByZero), e2.dz);
                chk("dut2_done_cycle", cyc, e2.cyc);
            end
        end
    end

    // Drives a one-cycle start pulse; returns the accepting edge number.
    task automatic issue(input int a, input int b, input int q, input int r, input int dz,
                         input bit expectResult, output int n);
        @(negedge clk);
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        bus.start    = 1'b1;
        n = cyc + 1;
        if (expectResult) sb1.push_back('{q, r, dz, n + lat(a, b)});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic settle();
        repeat (W + 4) @(negedge clk);
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_quotient"}, int'(bus.quotient), 0);
        chk({tag, "_remainder"}, int'(bus.remainder), 0);
        chk({tag, "_divByZero"}, int'(bus.divByZero), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_quotientDone"}, int'(bus.quotientDone), 0);
    endtask

    initial begin
        int  n;
        bit  seen;
        bus.start = 1'b0;  bus.dividend = '0;  bus.divisor = '0;
        bus2.start = 1'b0; bus2.dividend = '0; bus2.divisor = '0;

        repeat (2) @(negedge clk);
        chkZero("reset");
        chk("reset_dut2_quotient", int'(bus2.quotient), 0);
        chk("reset_dut2_busy", int'(bus2.busy), 0);
        rst = 1'b1;
        @(negedge clk);

        issue(13, 3, 4, 1, 0, 1'b1, n);
        chk("busy_in_calc", int'(bus.busy), 1);
        settle();
        issue(15, 1, 15, 0, 0, 1'b1, n);
        settle();
        issue(0, 5, 0, 0, 0, 1'b1, n);
        settle();
        issue(7, 0, 15, 7, 1, 1'b1, n);
        settle();
        issue(15, 2, 7, 1, 0, 1'b1, n);
        settle();
        issue(10, 10, 1, 0, 0, 1'b1, n);
        settle();

        // second start mid-operation must be ignored, latched operands kept
        issue(9, 2, 4, 1, 0, 1'b1, n);
        bus.dividend = 4'd15;
        bus.divisor  = 4'd15;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 4'd3;
        bus.divisor  = 4'd7;
        settle();

        // start held in the done cycle is deferred by one edge
        issue(8, 3, 2, 2, 0, 1'b1, n);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.quotientDone) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen_before_timeout", int'(seen), 1);
        chk("busy_low_in_done_cycle", int'(bus.busy), 0);
        bus.dividend = 4'd14;
        bus.divisor  = 4'd4;
        bus.start    = 1'b1;
        sb1.push_back('{3, 2, 0, cyc + 2 + lat(14, 4)});
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        settle();

        // reset mid-calc aborts without a done pulse
        issue(13, 3, 0, 0, 0, 1'b0, n);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chkZero("abort");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        issue(6, 4, 1, 2, 0, 1'b1, n);
        settle();

        // two instances with a shared start: latency must not depend on data
        @(negedge clk);
        bus.dividend  = 4'd2;  bus.divisor  = 4'd9; bus.start  = 1'b1;
        bus2.dividend = 4'd14; bus2.divisor = 4'd9; bus2.start = 1'b1;
        n = cyc + 1;
        sb1.push_back('{0, 2, 0, n + lat(2, 9)});
        sb2.push_back('{1, 5, 0, n + lat(14, 9)});
        @(negedge clk);
        bus.start  = 1'b0;
        bus2.start = 1'b0;

        for (int i = 0; i < 30; i++) begin
            if (sb1.size() == 0 && sb2.size() == 0) break;
            @(negedge clk);
        end
        while (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            checks++;
            errors++;
            $display("FAIL dut1_missing_done: got no result, expected quotient=%0d at cycle %0d", e1.q, e1.cyc);
        end
        while (sb2.size() > 0) begin
            e2 = sb2.pop_front();
            checks++;
            errors++;
            $display("FAIL dut2_missing_done: got no result, expected quotient=%0d at cycle %0d", e2.q, e2.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
